// File: rtl/dot_glyph_loader_pkg.sv
// Shared types and constants for the dot-matrix glyph loader.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;

    localparam logic [6:0] CHAR_MIN      = 7'h20;
    localparam logic [6:0] CHAR_MAX      = 7'h7E;
    localparam logic [6:0] CHAR_FALLBACK = 7'h3F;
    // The space glyph is all-zero, so a clear simply renders a space.
    localparam logic [6:0] CHAR_BLANK    = 7'h20;

    localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= CHAR_MIN) && (code <= CHAR_MAX);
    endfunction

endpackage

// File: rtl/dot_glyph_loader_if.sv
// Request and dot-controller bus between a requester and the glyph loader.
// Latency: none (wiring only).
// Backpressure: char_ready is high only when the loader can take a request.
// Optional: DOT_GLYPH_INVERT_EN adds the 'invert' request signal.
interface dot_glyph_loader_if;
    import dot_pkg::*;

`ifdef DOT_GLYPH_INVERT_EN
    logic                invert;
`endif
    logic                char_valid;
    logic [6:0]          char_code;
    logic                clear_req;
    logic                disp_en;
    logic                char_ready;
    logic [4:0]          dot_col_addr;
    logic [NUM_ROWS-1:0] dot_row;
    logic                dot_write;
    logic                dot_enable;
    logic                busy;
    logic                bad_char;

    modport master (
`ifdef DOT_GLYPH_INVERT_EN
        output invert,
`endif
        output char_valid,
        output char_code,
        output clear_req,
        output disp_en,
        input  char_ready,
        input  dot_col_addr,
        input  dot_row,
        input  dot_write,
        input  dot_enable,
        input  busy,
        input  bad_char
    );

    modport slave (
`ifdef DOT_GLYPH_INVERT_EN
        input  invert,
`endif
        input  char_valid,
        input  char_code,
        input  clear_req,
        input  disp_en,
        output char_ready,
        output dot_col_addr,
        output dot_row,
        output dot_write,
        output dot_enable,
        output busy,
        output bad_char
    );

endinterface

// File: rtl/dot_glyph_loader_font_rom.sv
// 95-entry 5x7 font (0x20..0x7E), one column per read; bit0 is the top row.
// Latency: 1 cycle, registered output updates only when i_en is high.
// Backpressure: none; output holds while i_en is low.
module dot_font_rom
    import dot_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_en,
    input  logic [6:0]          code,
    input  logic [2:0]          col,
    output logic [NUM_ROWS-1:0] o_row
);

    // Each entry packs columns 0..4 as bytes from MSB to LSB.
    logic [39:0] w_glyph;
    logic [7:0]  w_byte;
    logic        w_unused_msb;

    // Glyph lookup; unsupported codes read as blank.
    always_comb begin
        w_glyph = '0;
        case (code)
            7'h20: w_glyph = 40'h00_00_00_00_00;
            7'h21: w_glyph = 40'h00_00_5F_00_00;
            7'h22: w_glyph = 40'h00_07_00_07_00;
            7'h23: w_glyph = 40'h14_7F_14_7F_14;
            7'h24: w_glyph = 40'h24_2A_7F_2A_12;
            7'h25: w_glyph = 40'h23_13_08_64_62;
            7'h26: w_glyph = 40'h36_49_55_22_50;
            7'h27: w_glyph = 40'h00_05_03_00_00;
            7'h28: w_glyph = 40'h00_1C_22_41_00;
            7'h29: w_glyph = 40'h00_41_22_1C_00;
            7'h2A: w_glyph = 40'h14_08_3E_08_14;
            7'h2B: w_glyph = 40'h08_08_3E_08_08;
            7'h2C: w_glyph = 40'h00_50_30_00_00;
            7'h2D: w_glyph = 40'h08_08_08_08_08;
            7'h2E: w_glyph = 40'h00_60_60_00_00;
            7'h2F: w_glyph = 40'h20_10_08_04_02;
            7'h30: w_glyph = 40'h3E_51_49_45_3E;
            7'h31: w_glyph = 40'h00_42_7F_40_00;
            7'h32: w_glyph = 40'h42_61_51_49_46;
            7'h33: w_glyph = 40'h21_41_45_4B_31;
            7'h34: w_glyph = 40'h18_14_12_7F_10;
            7'h35: w_glyph = 40'h27_45_45_45_39;
            7'h36: w_glyph = 40'h3C_4A_49_49_30;
            7'h37: w_glyph = 40'h01_71_09_05_03;
            7'h38: w_glyph = 40'h36_49_49_49_36;
            7'h39: w_glyph = 40'h06_49_49_29_1E;
            7'h3A: w_glyph = 40'h00_36_36_00_00;
            7'h3B: w_glyph = 40'h00_56_36_00_00;
            7'h3C: w_glyph = 40'h08_14_22_41_00;
            7'h3D: w_glyph = 40'h14_14_14_14_14;
            7'h3E: w_glyph = 40'h00_41_22_14_08;
            7'h3F: w_glyph = 40'h02_01_51_09_06;
            7'h40: w_glyph = 40'h32_49_79_41_3E;
            7'h41: w_glyph = 40'h7E_11_11_11_7E;
            7'h42: w_glyph = 40'h7F_49_49_49_36;
            7'h43: w_glyph = 40'h3E_41_41_41_22;
            7'h44: w_glyph = 40'h7F_41_41_22_1C;
            7'h45: w_glyph = 40'h7F_49_49_49_41;
            7'h46: w_glyph = 40'h7F_09_09_09_01;
            7'h47: w_glyph = 40'h3E_41_49_49_7A;
            7'h48: w_glyph = 40'h7F_08_08_08_7F;
            7'h49: w_glyph = 40'h00_41_7F_41_00;
            7'h4A: w_glyph = 40'h20_40_41_3F_01;
            7'h4B: w_glyph = 40'h7F_08_14_22_41;
            7'h4C: w_glyph = 40'h7F_40_40_40_40;
            7'h4D: w_glyph = 40'h7F_02_0C_02_7F;
            7'h4E: w_glyph = 40'h7F_04_08_10_7F;
            7'h4F: w_glyph = 40'h3E_41_41_41_3E;
            7'h50: w_glyph = 40'h7F_09_09_09_06;
            7'h51: w_glyph = 40'h3E_41_51_21_5E;
            7'h52: w_glyph = 40'h7F_09_19_29_46;
            7'h53: w_glyph = 40'h46_49_49_49_31;
            7'h54: w_glyph = 40'h01_01_7F_01_01;
            7'h55: w_glyph = 40'h3F_40_40_40_3F;
            7'h56: w_glyph = 40'h1F_20_40_20_1F;
            7'h57: w_glyph = 40'h3F_40_38_40_3F;
            7'h58: w_glyph = 40'h63_14_08_14_63;
            7'h59: w_glyph = 40'h07_08_70_08_07;
            7'h5A: w_glyph = 40'h61_51_49_45_43;
            7'h5B: w_glyph = 40'h00_7F_41_41_00;
            7'h5C: w_glyph = 40'h02_04_08_10_20;
            7'h5D: w_glyph = 40'h00_41_41_7F_00;
            7'h5E: w_glyph = 40'h04_02_01_02_04;
            7'h5F: w_glyph = 40'h40_40_40_40_40;
            7'h60: w_glyph = 40'h00_01_02_04_00;
            7'h61: w_glyph = 40'h20_54_54_54_78;
            7'h62: w_glyph = 40'h7F_48_44_44_38;
            7'h63: w_glyph = 40'h38_44_44_44_20;
            7'h64: w_glyph = 40'h38_44_44_48_7F;
            7'h65: w_glyph = 40'h38_54_54_54_18;
            7'h66: w_glyph = 40'h08_7E_09_01_02;
            7'h67: w_glyph = 40'h0C_52_52_52_3E;
            7'h68: w_glyph = 40'h7F_08_04_04_78;
            7'h69: w_glyph = 40'h00_44_7D_40_00;
            7'h6A: w_glyph = 40'h20_40_44_3D_00;
            7'h6B: w_glyph = 40'h7F_10_28_44_00;
            7'h6C: w_glyph = 40'h00_41_7F_40_00;
            7'h6D: w_glyph = 40'h7C_04_18_04_78;
            7'h6E: w_glyph = 40'h7C_08_04_04_78;
            7'h6F: w_glyph = 40'h38_44_44_44_38;
            7'h70: w_glyph = 40'h7C_14_14_14_08;
            7'h71: w_glyph = 40'h08_14_14_18_7C;
            7'h72: w_glyph = 40'h7C_08_04_04_08;
            7'h73: w_glyph = 40'h48_54_54_54_20;
            7'h74: w_glyph = 40'h04_3F_44_40_20;
            7'h75: w_glyph = 40'h3C_40_40_20_7C;
            7'h76: w_glyph = 40'h1C_20_40_20_1C;
            7'h77: w_glyph = 40'h3C_40_30_40_3C;
            7'h78: w_glyph = 40'h44_28_10_28_44;
            7'h79: w_glyph = 40'h0C_50_50_50_3C;
            7'h7A: w_glyph = 40'h44_64_54_4C_44;
            7'h7B: w_glyph = 40'h00_08_36_41_00;
            7'h7C: w_glyph = 40'h00_00_7F_00_00;
            7'h7D: w_glyph = 40'h00_41_36_08_00;
            7'h7E: w_glyph = 40'h10_08_08_10_08;
            default: w_glyph = '0;
        endcase
    end

    // Column select out of the packed glyph.
    always_comb begin
        w_byte = '0;
        case (col)
            3'd0:    w_byte = w_glyph[39:32];
            3'd1:    w_byte = w_glyph[31:24];
            3'd2:    w_byte = w_glyph[23:16];
            3'd3:    w_byte = w_glyph[15:8];
            3'd4:    w_byte = w_glyph[7:0];
            default: w_byte = '0;
        endcase
    end

    // Font bytes only use 7 rows; the top bit is always zero.
    assign w_unused_msb = w_byte[7];

    // Registered read port, held when not enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_row <= '0;
        end else if (i_en) begin
            o_row <= w_byte[NUM_ROWS-1:0];
        end
    end

endmodule

// File: rtl/dot_glyph_loader.sv
// Loads one 5x7 glyph (or a blank) column by column into a dot-matrix controller.
// Latency: char_ready returns 1+5*(HOLD_CYCLES+1) cycles after the accept edge.
// Backpressure: requests are level-sampled only in IDLE; requests while busy are dropped.
// Optional: DOT_GLYPH_INVERT_EN adds an 'invert' request bit that inverts every written row.
module dot_glyph_loader
    import dot_pkg::*;
#(
    parameter int HOLD_CYCLES = 3
) (
    input  logic          clk,
    input  logic          reset,
    dot_glyph_loader_if.slave bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_rom_en;
    logic                w_write;
    logic                w_last_hold;
    logic [2:0]          w_rom_col;
    logic [2:0]          r_col;
    logic [3:0]          r_hold;
    logic [6:0]          r_code;
    logic                r_bad_char;
    logic                r_dot_enable;
    logic [NUM_ROWS-1:0] w_rom_row;
    logic [NUM_ROWS-1:0] w_row;

    assign w_last_hold = (r_hold == 4'(HOLD_CYCLES - 1));

    // State register; reset aborts any glyph in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state controls. The ROM is read in LOAD for column 0
    // and in each GAP for the following column, so its registered output
    // switches exactly on the edge that enters WRITE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rom_en    = 1'b0;
        w_write     = 1'b0;
        w_rom_col   = r_col;
        case (r_state)
            ST_IDLE: begin
                if (bus.char_valid || bus.clear_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_rom_en    = 1'b1;
                w_rom_col   = 3'd0;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_write = 1'b1;
                if (w_last_hold) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_col == LAST_COL) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rom_en    = 1'b1;
                    w_rom_col   = r_col + 3'd1;
                    w_state_nxt = ST_WRITE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, column/hold counters and the bad-code pulse. The
    // column counter is only rewound on LOAD->WRITE so the address seen by
    // the dot controller holds through IDLE and LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col      <= 3'd0;
            r_hold     <= 4'd0;
            r_code     <= CHAR_BLANK;
            r_bad_char <= 1'b0;
        end else begin
            r_bad_char <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (bus.clear_req) begin
                            r_code <= CHAR_BLANK;
                        end else if (is_printable(bus.char_code)) begin
                            r_code <= bus.char_code;
                        end else begin
                            r_code     <= CHAR_FALLBACK;
                            r_bad_char <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    r_col  <= 3'd0;
                    r_hold <= 4'd0;
                end
                ST_WRITE: begin
                    r_hold <= w_last_hold ? 4'd0 : r_hold + 4'd1;
                end
                ST_GAP: begin
                    if (r_col != LAST_COL) begin
                        r_col <= r_col + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Display enable is a plain one-cycle delay of the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dot_enable <= 1'b0;
        end else begin
            r_dot_enable <= bus.disp_en;
        end
    end

    dot_font_rom u_font_rom (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_rom_en),
        .code  (r_code),
        .col   (w_rom_col),
        .o_row (w_rom_row)
    );

`ifdef DOT_GLYPH_INVERT_EN
    logic r_invert;
    logic r_invert_q;

    // Invert is captured at accept but only applied alongside a ROM read so
    // the driven row stays stable in IDLE and LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_invert   <= 1'b0;
            r_invert_q <= 1'b0;
        end else begin
            if (w_accept) begin
                r_invert <= bus.invert;
            end
            if (w_rom_en) begin
                r_invert_q <= r_invert;
            end
        end
    end

    assign w_row = w_rom_row ^ {NUM_ROWS{r_invert_q}};
`else
    assign w_row = w_rom_row;
`endif

    assign bus.char_ready   = (r_state == ST_IDLE);
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.dot_write    = w_write;
    assign bus.dot_col_addr = {2'b00, r_col};
    assign bus.dot_row      = w_row;
    assign bus.dot_enable   = r_dot_enable;
    assign bus.bad_char     = r_bad_char;

endmodule

// File: tb/tb_dot_glyph_loader.sv
// Self-checking bench for dot_glyph_loader (default and HOLD_CYCLES=1 builds).
// Latency: n/a.
// Backpressure: n/a.
module tb_dot_glyph_loader;

    logic       clk;
    logic       reset;
    logic       sel;
    logic       t_valid;
    logic       t_clear;
    logic       t_disp;
    logic [6:0] t_code;

    int n_total;
    int n_bad;

    logic [4:0] last_addr [2];
    logic [6:0] last_row  [2];

    dot_glyph_loader_if bus_a ();
    dot_glyph_loader_if bus_b ();

    assign bus_a.char_valid = t_valid & ~sel;
    assign bus_a.clear_req  = t_clear & ~sel;
    assign bus_a.char_code  = t_code;
    assign bus_a.disp_en    = t_disp;
    assign bus_b.char_valid = t_valid & sel;
    assign bus_b.clear_req  = t_clear & sel;
    assign bus_b.char_code  = t_code;
    assign bus_b.disp_en    = t_disp;
`ifdef DOT_GLYPH_INVERT_EN
    assign bus_a.invert = 1'b0;
    assign bus_b.invert = 1'b0;
`endif

    dot_glyph_loader #(.HOLD_CYCLES(3)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    dot_glyph_loader #(.HOLD_CYCLES(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic       o_write, o_busy, o_ready, o_bad, o_enable;
    logic [4:0] o_addr;
    logic [6:0] o_row;
    assign o_write  = sel ? bus_b.dot_write    : bus_a.dot_write;
    assign o_busy   = sel ? bus_b.busy         : bus_a.busy;
    assign o_ready  = sel ? bus_b.char_ready   : bus_a.char_ready;
    assign o_bad    = sel ? bus_b.bad_char     : bus_a.bad_char;
    assign o_enable = sel ? bus_b.dot_enable   : bus_a.dot_enable;
    assign o_addr   = sel ? bus_b.dot_col_addr : bus_a.dot_col_addr;
    assign o_row    = sel ? bus_b.dot_row      : bus_a.dot_row;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference glyphs for the codes the bench uses; anything outside the
    // printable range renders as '?', a clear renders blank.
    function automatic logic [6:0] ref_col(input logic [6:0] code, input bit clr, input int col);
        logic [6:0]  c;
        logic [39:0] g;
        if (clr) return 7'h00;
        c = (code < 7'h20 || code > 7'h7E) ? 7'h3F : code;
        case (c)
            7'h20:   g = 40'h00_00_00_00_00;
            7'h3F:   g = 40'h02_01_51_09_06;
            7'h41:   g = 40'h7E_11_11_11_7E;
            7'h30:   g = 40'h3E_51_49_45_3E;
            7'h48:   g = 40'h7F_08_08_08_7F;
            default: g = 40'hFF_FF_FF_FF_FF;
        endcase
        return g[8*(4-col) +: 7];
    endfunction

    task automatic start(input logic [6:0] code, input bit v, input bit c);
        @(negedge clk);
        t_code  = code;
        t_valid = v;
        t_clear = c;
    endtask

    // Called at a negedge with a request already presented. Follows the
    // whole transaction cycle by cycle against the expected column sequence.
    task automatic run_trace(input logic [6:0] code, input bit clr, input bit keep,
                             input logic [6:0] next_code, input int exp_lat, input string name);
        int h, n, lat, col, ph, j;
        logic       exp_bad, e_w, e_busy, e_rdy, e_bad, e_en;
        logic [4:0] e_addr;
        logic [6:0] e_row;
        logic [6:0] g [5];
        h = sel ? 1 : 3;
        n = 2 + 5 * (h + 1);
        for (int c = 0; c < 5; c++) g[c] = ref_col(code, clr, c);
        exp_bad = !clr && (code < 7'h20 || code > 7'h7E);
        n_total++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_before_accept got=%b want=1", name, o_ready);
        end
        e_en = t_disp;
        lat  = -1;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (keep) t_code = next_code;
                else begin
                    t_valid = 1'b0;
                    t_clear = 1'b0;
                end
            end
            if (k == 1) begin
                e_w = 1'b0; e_busy = 1'b1; e_rdy = 1'b0; e_bad = exp_bad;
                e_addr = last_addr[sel]; e_row = last_row[sel];
            end else if (k < n) begin
                j = k - 2; col = j / (h + 1); ph = j % (h + 1);
                e_w = (ph < h); e_busy = 1'b1; e_rdy = 1'b0; e_bad = 1'b0;
                e_addr = 5'(col); e_row = g[col];
            end else begin
                e_w = 1'b0; e_busy = 1'b0; e_rdy = 1'b1; e_bad = 1'b0;
                e_addr = 5'd4; e_row = g[4];
            end
            n_total++;
            if ({o_write, o_busy, o_ready, o_bad, o_addr, o_row} !==
                {e_w, e_busy, e_rdy, e_bad, e_addr, e_row}) begin
                n_bad++;
                $display("FAIL %s k=%0d got w=%b busy=%b rdy=%b bad=%b addr=%0d row=%h want w=%b busy=%b rdy=%b bad=%b addr=%0d row=%h",
                         name, k, o_write, o_busy, o_ready, o_bad, o_addr, o_row,
                         e_w, e_busy, e_rdy, e_bad, e_addr, e_row);
            end
            if (o_ready === 1'b1 && lat < 0) lat = k - 1;
            n_total++;
            if (o_enable !== e_en) begin
                n_bad++;
                $display("FAIL %s dot_enable k=%0d got=%b want=%b", name, k, o_enable, e_en);
            end
            t_disp = 1'($urandom_range(0, 1));
            e_en   = t_disp;
        end
        last_addr[sel] = 5'd4;
        last_row[sel]  = g[4];
        n_total++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL %s ready_latency got=%0d want=%0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; t_valid = 1'b1; t_disp = 1'b1; t_code = 7'h41;
        repeat (3) @(negedge clk);
        n_total++;
        if ({o_write, o_addr, o_row, o_enable, o_busy, o_bad, o_ready} !==
            {1'b0, 5'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_values got w=%b addr=%0d row=%h en=%b busy=%b bad=%b rdy=%b",
                     o_write, o_addr, o_row, o_enable, o_busy, o_bad, o_ready);
        end
        reset = 1'b0; t_valid = 1'b0; t_disp = 1'b0;
        @(negedge clk);
        n_total++;
        if ({o_busy, o_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_release got busy=%b rdy=%b want busy=0 rdy=1", o_busy, o_ready);
        end
    endtask

    task automatic test_char_a();
        start(7'h41, 1'b1, 1'b0);
        run_trace(7'h41, 1'b0, 1'b0, 7'h00, 21, "char_A");
    endtask

    task automatic test_clear_priority();
        start(7'h41, 1'b1, 1'b1);
        run_trace(7'h41, 1'b1, 1'b0, 7'h00, 21, "clear_priority");
    endtask

    task automatic test_bad_char();
        start(7'h05, 1'b1, 1'b0);
        run_trace(7'h05, 1'b0, 1'b0, 7'h00, 21, "bad_char");
    endtask

    task automatic test_back_to_back();
        start(7'h48, 1'b1, 1'b0);
        run_trace(7'h48, 1'b0, 1'b1, 7'h30, 21, "busy_hold_first");
        run_trace(7'h30, 1'b0, 1'b0, 7'h00, 21, "busy_hold_second");
    endtask

    task automatic test_reset_mid_write();
        start(7'h41, 1'b1, 1'b0);
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) t_valid = 1'b0;
        end
        n_total++;
        if ({o_write, o_addr} !== {1'b1, 5'd2}) begin
            n_bad++;
            $display("FAIL midwrite_setup got w=%b addr=%0d want w=1 addr=2", o_write, o_addr);
        end
        reset = 1'b1; t_disp = 1'b1; t_valid = 1'b1;
        @(negedge clk);
        n_total++;
        if ({o_write, o_busy, o_ready, o_addr, o_row, o_enable, o_bad} !==
            {1'b0, 1'b0, 1'b1, 5'd0, 7'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL midwrite_reset got w=%b busy=%b rdy=%b addr=%0d row=%h en=%b bad=%b",
                     o_write, o_busy, o_ready, o_addr, o_row, o_enable, o_bad);
        end
        reset = 1'b0; t_valid = 1'b0;
        last_addr[0] = 5'd0; last_row[0] = 7'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_total++;
            if ({o_write, o_busy, o_ready, o_enable} !== 4'b0011) begin
                n_bad++;
                $display("FAIL midwrite_no_resume c=%0d got w=%b busy=%b rdy=%b en=%b want 0 0 1 1",
                         k, o_write, o_busy, o_ready, o_enable);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] code;
        bit         c, v;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 6))
                0: code = 7'h20;
                1: code = 7'h3F;
                2: code = 7'h41;
                3: code = 7'h30;
                4: code = 7'h48;
                5: code = 7'($urandom_range(0, 31));
                default: code = 7'h7F;
            endcase
            c = ($urandom_range(0, 3) == 0);
            v = c ? 1'($urandom_range(0, 1)) : 1'b1;
            start(code, v, c);
            run_trace(code, c, 1'b0, 7'h00, 21, "random");
        end
    endtask

    task automatic test_hold1();
        @(negedge clk);
        sel = 1'b1;
        start(7'h20, 1'b1, 1'b0);
        run_trace(7'h20, 1'b0, 1'b0, 7'h00, 11, "hold1_space");
        sel = 1'b0;
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        sel = 1'b0; reset = 1'b1;
        t_valid = 1'b0; t_clear = 1'b0; t_disp = 1'b0; t_code = 7'h00;
        last_addr[0] = 5'd0; last_addr[1] = 5'd0;
        last_row[0]  = 7'd0; last_row[1]  = 7'd0;
        test_reset();
        test_char_a();
        test_clear_priority();
        test_bad_char();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        test_hold1();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dot_glyph_loader.md
DOT_GLYPH_LOADER -- requirements
Module: dot_glyph_loader

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 3: cycles dot_write is held high per column (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port char_valid  input  1  character request valid.
REQ-005 SHALL have port char_code  input  7  ASCII code of requested glyph.
REQ-006 SHALL have port clear_req  input  1  request to blank all 5 columns.
REQ-007 SHALL have port disp_en  input  1  display enable request.
REQ-008 SHALL have port char_ready  output  1  loader can accept a request.
REQ-009 SHALL have port dot_col_addr  output  5  column address to dot controller.
REQ-010 SHALL have port dot_row  output  7  row pattern for addressed column; bit0 = top row.
REQ-011 SHALL have port dot_write  output  1  column write strobe to dot controller.
REQ-012 SHALL have port dot_enable  output  1  display enable to dot controller.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port bad_char  output  1  one-cycle pulse when an unsupported code is accepted.

Function
REQ-015 States SHALL be IDLE, LOAD, WRITE, GAP; char_ready = 1 only in IDLE.
REQ-016 Accept SHALL occur on an edge in IDLE with char_valid=1 or clear_req=1; clear_req wins when both are high.
REQ-017 On accept, state SHALL go IDLE->LOAD; char_code (or blank for clear) is captured; font ROM is read during LOAD (1-cycle latency).
REQ-018 LOAD->WRITE column 0; WRITE SHALL last exactly HOLD_CYCLES cycles with dot_write=1, dot_col_addr=column, dot_row=glyph column.
REQ-019 WRITE->GAP; GAP SHALL last 1 cycle with dot_write=0 and addr/row held; GAP->WRITE on next column, or GAP->IDLE after column 4.
REQ-020 Columns SHALL be written in order 0,1,2,3,4; char_ready reasserts exactly 1+5*(HOLD_CYCLES+1) cycles after the accept edge (21 at default).
REQ-021 A clear SHALL write dot_row=0 to all 5 columns with identical timing.
REQ-022 Codes outside 0x20..0x7E SHALL render glyph 0x3F ('?') and pulse bad_char in the LOAD cycle.
REQ-023 Requests while busy SHALL be ignored, not queued; char_valid/clear_req are level-sampled only in IDLE.
REQ-024 dot_enable SHALL equal disp_en registered one cycle, independent of state.
REQ-025 In IDLE, dot_write=0; dot_col_addr and dot_row SHALL hold their last driven values.
REQ-026 Column counter SHALL be 3 bits internally, never exceed 4, and is zero-extended onto dot_col_addr.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE from any state, including mid-WRITE, regardless of other inputs.
REQ-028 Reset values: dot_write=0, dot_col_addr=0, dot_row=0, dot_enable=0, busy=0, bad_char=0, char_ready=1 after release.
REQ-029 A glyph aborted by reset SHALL NOT be resumed; columns already written remain in the dot controller.

Configuration
REQ-030 Macro DOT_GLYPH_INVERT_EN defined: extra input port invert (1 bit) is sampled at accept, and all 7 row bits of every written column (including clears) are inverted.
REQ-031 DOT_GLYPH_INVERT_EN undefined: no invert port; rows are driven exactly as stored.

Structure
REQ-032 Shared package dot_pkg SHALL hold the state enum, NUM_COLS=5, NUM_ROWS=7, CHAR_MIN=0x20, CHAR_MAX=0x7E, CHAR_FALLBACK=0x3F.
REQ-033 Sub-module dot_font_rom SHALL hold the 95-entry 5x7 font, registered output, inputs code[6:0] and col[2:0].

Verification
REQ-034 Reset, then char 0x41 ('A') -> columns 0..4 written with rows 0x7E,0x11,0x11,0x11,0x7E, each dot_write high 3 cycles, 1-cycle gaps; ready at accept+21.
REQ-035 char_valid and clear_req high together in IDLE -> five writes of 0x00, char ignored.
REQ-036 char 0x05 -> bad_char single pulse in LOAD, '?' glyph written.
REQ-037 reset asserted during column 2 WRITE -> next cycle dot_write=0, state IDLE, char_ready=1 after release.
REQ-038 New char_valid held high during busy -> no effect until IDLE; accepted on first IDLE edge.
REQ-039 HOLD_CYCLES=1 build, char 0x20 -> five 0x00 writes, ready at accept+11.
